// File: rtl/wdt_tick_watchdog_if.sv
// wdt_tick_watchdog_if: 16-bit, 3-bit-address slave register bus of the watchdog.
interface wdt_tick_watchdog_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/wdt_tick_watchdog.sv
// wdt_tick_watchdog: tick-driven watchdog with warning irq, grace period and sticky reset request.
// Optional WDT_LOCK_EN: locks CONTROL.enable, TIMEOUT and GRACE once enabled.
module wdt_tick_watchdog #(
  parameter logic [15:0] KICK_KEY    = 16'hC0DE,
  parameter logic [15:0] TIMEOUT_RST = 16'd1000,
  parameter logic [15:0] GRACE_RST   = 16'd100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  wdt_tick_watchdog_if.slave bus,
  output logic              irq,
  output logic              wdt_reset_req
);
  typedef enum logic [1:0] {DISABLED = 2'd0, RUNNING = 2'd1, WARNING = 2'd2, EXPIRED = 2'd3} state_t;
  state_t      state, state_nx;
  logic [15:0] count, count_nx, timeout, grace, rd_nx;
  logic        enable, irq_en, warn, expired, bad_key, locked;
  logic        wr, live, ctrl_wr, kick_wr, st_clr, cfg_wr, en_wd, warn_set, exp_set, bad_set;
  assign wr      = bus.chipselect && !bus.write_n;
  assign live    = state == RUNNING || state == WARNING;
  assign ctrl_wr = wr && bus.address == 3'd1 && state != EXPIRED;
  assign kick_wr = wr && bus.address == 3'd4 && live;
  assign st_clr  = wr && bus.address == 3'd0;
  assign cfg_wr  = wr && state != EXPIRED && !locked;
  assign en_wd   = bus.writedata[0] || locked;
  assign irq     = warn && irq_en;
`ifdef WDT_LOCK_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) locked <= 1'b0;
    else if (ctrl_wr && bus.writedata[0]) locked <= 1'b1;
`else
  assign locked = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    count_nx = count;
    warn_set = 1'b0;
    exp_set  = 1'b0;
    bad_set  = kick_wr && bus.writedata != KICK_KEY;
    case (state)
      DISABLED: if (ctrl_wr && en_wd) begin
        state_nx = RUNNING;
        count_nx = timeout;
      end
      RUNNING, WARNING: begin
        if (ctrl_wr && !en_wd) state_nx = DISABLED;
        else if (kick_wr && !bad_set) begin
          state_nx = RUNNING;
          count_nx = timeout;
        end else if (tick && count != 16'd0) count_nx = count - 16'd1;
        else if (tick && state == RUNNING) begin
          state_nx = WARNING;
          count_nx = grace;
          warn_set = 1'b1;
        end else if (tick) begin
          state_nx = EXPIRED;
          exp_set  = 1'b1;
        end
      end
      default: count_nx = 16'd0;
    endcase
  end
  always_comb begin
    rd_nx = bus.address == 3'd0 ? {10'd0, locked, state, bad_key, expired, warn} :
            bus.address == 3'd1 ? {14'd0, irq_en, enable} :
            bus.address == 3'd2 ? timeout :
            bus.address == 3'd3 ? grace :
            bus.address == 3'd5 ? count : 16'd0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= DISABLED;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count         <= 16'd0;
      timeout       <= TIMEOUT_RST;
      grace         <= GRACE_RST;
      enable        <= 1'b0;
      irq_en        <= 1'b0;
      warn          <= 1'b0;
      expired       <= 1'b0;
      bad_key       <= 1'b0;
      wdt_reset_req <= 1'b0;
      bus.readdata  <= 16'd0;
    end else begin
      count <= count_nx;
      if (ctrl_wr) begin
        enable <= en_wd;
        irq_en <= bus.writedata[1];
      end
      if (cfg_wr && bus.address == 3'd2) timeout <= bus.writedata;
      if (cfg_wr && bus.address == 3'd3) grace <= bus.writedata;
      warn          <= warn_set || (warn && !st_clr);
      bad_key       <= bad_set || (bad_key && !st_clr);
      expired       <= expired || exp_set;
      wdt_reset_req <= wdt_reset_req || exp_set;
      bus.readdata  <= rd_nx;
    end
endmodule
